// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op encoding, binary32 field constants, int32 saturation limits
// and the S1 register layout of the format-conversion unit.
package fpu_pkg;

   typedef enum logic {
      FCVT_ITOF = 1'b0,
      FCVT_FTOI = 1'b1
   } fcvt_op_e;

   localparam int FP_BIAS   = 127;
   localparam int FP_FRAC_W = 23;
   localparam int FP_EXP_W  = 8;

   localparam logic [31:0] INT_MAX = 32'h7FFFFFFF;
   localparam logic [31:0] INT_MIN = 32'h80000000;

   // mag holds |int| for itof or the 24-bit significand for ftoi; sh is the leading-zero
   // count for itof or the significand shift distance for ftoi.
   typedef struct packed {
      fcvt_op_e    op;
      logic        sgn;
      logic        zero;
      logic        sat;
      logic        shl;
      logic [5:0]  sh;
      logic [31:0] mag;
   } fcvt_s1_t;

endpackage

// File: rtl/fcvt_lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero input yields 32.
module lzc32 (
   input  logic [31:0] a_i,
   output logic [5:0]  cnt_o
);

   always_comb begin
      cnt_o = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (a_i[i]) cnt_o = 6'(31 - i);
      end
   end

endmodule

// File: rtl/fcvt.sv
// Two-stage int32 <-> binary32 converter with valid/ready backpressure.
// Define FCVT_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fcvt
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        op,
   input  logic [31:0] x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y
);

`ifdef FCVT_ROUND_NEAREST_EN
   localparam logic RNE = 1'b1;
`else
   localparam logic RNE = 1'b0;
`endif

   localparam logic [7:0] EXP_INT_TOP = 8'(FP_BIAS + 31);
   localparam logic [7:0] EXP_UNIT    = 8'(FP_BIAS + FP_FRAC_W);

   function automatic logic rnd_inc(input logic lsb, input logic rbit, input logic sticky);
      return RNE & rbit & (sticky | lsb);
   endfunction

   logic                  vld_p1_q, vld_p2_q;
   logic                  adv;
   fcvt_s1_t              s1_p1_d, s1_p1_q;
   logic [31:0]           y_d, y_q;

   logic [FP_EXP_W-1:0]   xe_p0;
   logic [31:0]           imag_p0;
   logic [5:0]            lz_p0;
   logic [7:0]            zlim_p0;

   assign adv       = !vld_p2_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_p2_q;
   assign y         = y_q;

   // ---- S1: classify, magnitude, leading-zero count / shift distance ----
   assign xe_p0   = x[FP_FRAC_W +: FP_EXP_W];
   assign imag_p0 = x[31] ? (~x + 32'd1) : x;
   // Round-to-nearest lets e = 126 (0.5..1.0) reach magnitude 1.
   assign zlim_p0 = RNE ? 8'(FP_BIAS - 1) : 8'(FP_BIAS);

   lzc32 u_lzc (
      .a_i   (imag_p0),
      .cnt_o (lz_p0)
   );

   always_comb begin
      s1_p1_d      = '0;
      s1_p1_d.op   = fcvt_op_e'(op);
      s1_p1_d.sgn  = x[31];
      s1_p1_d.mag  = imag_p0;
      s1_p1_d.sh   = lz_p0;
      s1_p1_d.zero = (x == 32'd0);
      if (fcvt_op_e'(op) == FCVT_FTOI) begin
         s1_p1_d.mag  = {8'd0, 1'b1, x[FP_FRAC_W-1:0]};
         s1_p1_d.zero = (xe_p0 < zlim_p0);
         s1_p1_d.sat  = (xe_p0 >= EXP_INT_TOP);
         s1_p1_d.shl  = (xe_p0 >= EXP_UNIT);
         s1_p1_d.sh   = s1_p1_d.shl ? 6'(xe_p0 - EXP_UNIT) : 6'(EXP_UNIT - xe_p0);
      end
   end

   // ---- S2: shift, round, pack ----
   logic [31:0]        lsh_p1;
   logic [63:0]        rsh_p1;
   logic               inc_i_p1, inc_f_p1, carry_p1;
   logic [22:0]        frac_p1;
   logic [7:0]         exp_p1;
   logic [31:0]        fmag_p1;
   logic signed [31:0] ires_p1;

   assign lsh_p1 = s1_p1_q.mag << s1_p1_q.sh;
   assign rsh_p1 = {s1_p1_q.mag, 32'd0} >> s1_p1_q.sh;

   always_comb begin
      inc_i_p1            = rnd_inc(lsh_p1[8], lsh_p1[7], |lsh_p1[6:0]);
      {carry_p1, frac_p1} = {1'b0, lsh_p1[30:8]} + {23'd0, inc_i_p1};
      exp_p1              = EXP_INT_TOP - {2'b00, s1_p1_q.sh} + {7'd0, carry_p1};

      inc_f_p1 = rnd_inc(rsh_p1[32], rsh_p1[31], |rsh_p1[30:0]);
      fmag_p1  = s1_p1_q.shl ? lsh_p1 : (rsh_p1[63:32] + {31'd0, inc_f_p1});
      ires_p1  = s1_p1_q.sgn ? -$signed(fmag_p1) : $signed(fmag_p1);

      y_d = 32'd0;
      if (!s1_p1_q.zero) begin
         if (s1_p1_q.op == FCVT_ITOF) y_d = {s1_p1_q.sgn, exp_p1, frac_p1};
         else if (s1_p1_q.sat)        y_d = s1_p1_q.sgn ? INT_MIN : INT_MAX;
         else                         y_d = ires_p1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         y_q      <= 32'd0;
      end else if (adv) begin
         vld_p1_q <= in_valid;
         vld_p2_q <= vld_p1_q;
         y_q      <= y_d;
      end
   end

   always_ff @(posedge clk) begin
      if (adv) s1_p1_q <= s1_p1_d;
   end

endmodule

// File: tb/tb_fcvt.sv
// Directed self-checking bench for fcvt: conversions, rounding, saturation,
// backpressure and asynchronous reset; expectations follow FCVT_ROUND_NEAREST_EN.
module tb_fcvt;

`ifdef FCVT_ROUND_NEAREST_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        op = 1'b0;
   logic [31:0] x = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] y;

   int n_chk = 0;
   int n_err = 0;

   fcvt dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   // One isolated op: present before edge A, accepted at A, result visible after edge A+1.
   task automatic run_op(input string tag, input logic o, input logic [31:0] v,
                         input logic [31:0] exp);
      @(negedge clk);
      op = o; x = v; in_valid = 1'b1; out_ready = 1'b1;
      #1 check({tag, "/rdy"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check({tag, "/early"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      #1 check({tag, "/vld"}, 32'(out_valid), 32'd1);
      check(tag, y, exp);
   endtask

   logic [31:0] bx[6];
   logic        bop[6];
   logic [31:0] bexp[6];

   initial begin
      int          ia, ko;
      logic        acc;
      logic [31:0] yhold;

      // Reset state
      #1;
      check("rst_vld", 32'(out_valid), 32'd0);
      check("rst_y", y, 32'd0);
      check("rst_rdy", 32'(in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // itof
      run_op("itof_1",    1'b0, 32'd1,          32'h3F800000);
      run_op("itof_m1",   1'b0, 32'hFFFFFFFF,   32'hBF800000);
      run_op("itof_0",    1'b0, 32'd0,          32'h00000000);
      run_op("itof_min",  1'b0, 32'h80000000,   32'hCF000000);
      run_op("itof_m5",   1'b0, 32'hFFFFFFFB,   32'hC0A00000);
      run_op("itof_max",  1'b0, 32'h7FFFFFFF,   RNE ? 32'h4F000000 : 32'h4EFFFFFF);
      run_op("itof_tie",  1'b0, 32'h01000001,   32'h4B800000);

      // ftoi
      run_op("ftoi_2p5",  1'b1, 32'h40200000,   32'd2);
      run_op("ftoi_3p5",  1'b1, 32'h40600000,   RNE ? 32'd4 : 32'd3);
      run_op("ftoi_m1p5", 1'b1, 32'hBFC00000,   RNE ? 32'hFFFFFFFE : 32'hFFFFFFFF);
      run_op("ftoi_0p75", 1'b1, 32'h3F400000,   RNE ? 32'd1 : 32'd0);
      run_op("ftoi_0p5",  1'b1, 32'h3F000000,   32'd0);
      run_op("ftoi_big",  1'b1, 32'h4EFFFFFF,   32'h7FFFFF80);
      run_op("ftoi_mbig", 1'b1, 32'hCEFFFFFF,   32'h80000080);
      run_op("ftoi_lsh1", 1'b1, 32'h4B800001,   32'h01000002);
      run_op("ftoi_satp", 1'b1, 32'h4F000000,   32'h7FFFFFFF);
      run_op("ftoi_satn", 1'b1, 32'hCF000000,   32'h80000000);
      run_op("ftoi_nan",  1'b1, 32'h7FC00000,   32'h7FFFFFFF);
      run_op("ftoi_den",  1'b1, 32'h00000001,   32'h00000000);

      // Backpressure: out_ready low during cycles 2..4 of a 6-op stream
      bop[0] = 1'b0; bx[0] = 32'd1;        bexp[0] = 32'h3F800000;
      bop[1] = 1'b1; bx[1] = 32'h40600000; bexp[1] = RNE ? 32'd4 : 32'd3;
      bop[2] = 1'b0; bx[2] = 32'hFFFFFFFF; bexp[2] = 32'hBF800000;
      bop[3] = 1'b1; bx[3] = 32'h4F000000; bexp[3] = 32'h7FFFFFFF;
      bop[4] = 1'b0; bx[4] = 32'h01000001; bexp[4] = 32'h4B800000;
      bop[5] = 1'b1; bx[5] = 32'hBFC00000; bexp[5] = RNE ? 32'hFFFFFFFE : 32'hFFFFFFFF;
      ia = 0; ko = 0; yhold = 32'd0;
      repeat (2) @(posedge clk);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         out_ready = !(c >= 2 && c <= 4);
         in_valid  = (ia < 6);
         if (ia < 6) begin
            op = bop[ia];
            x  = bx[ia];
         end
         #1;
         check($sformatf("bp_rdy_c%0d", c), 32'(in_ready), 32'(!(c >= 2 && c <= 4)));
         check($sformatf("bp_vld_c%0d", c), 32'(out_valid), 32'(c >= 2 && c <= 10));
         if (c == 2) yhold = y;
         if (c == 3 || c == 4) check($sformatf("bp_hold_c%0d", c), y, yhold);
         if (out_valid && out_ready) begin
            if (ko < 6) check($sformatf("bp_y%0d", ko), y, bexp[ko]);
            else        check("bp_extra", 32'(ko), 32'd5);
            ko++;
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         if (acc) ia++;
      end
      check("bp_out_cnt", 32'(ko), 32'd6);
      check("bp_in_cnt", 32'(ia), 32'd6);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;

      // Reset with both stages full
      @(negedge clk);
      op = 1'b0; x = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      x = 32'h80000000;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("rm_full_vld", 32'(out_valid), 32'd1);
      check("rm_full_y", y, 32'h3F800000);
      check("rm_full_rdy", 32'(in_ready), 32'd0);
      #2 rstn = 1'b0;
      #1;
      check("rm_async_vld", 32'(out_valid), 32'd0);
      check("rm_async_y", y, 32'd0);
      check("rm_async_rdy", 32'(in_ready), 32'd1);
      @(negedge clk);
      rstn = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 check("rm_drop1", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1 check("rm_drop2", 32'(out_valid), 32'd0);
      run_op("rm_after", 1'b0, 32'd5, 32'h40A00000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
